// File: rtl/booth_mul_seq_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Holds the FSM encoding, operand widths and the Booth digit decode.
package booth_mul_seq_pkg;

    localparam int WORD_W      = 32;
    localparam int BOOTH_STEPS = 16;
    // Two guard bits keep +/-2M exact even for the most negative multiplicand.
    localparam int PP_W        = WORD_W + 2;
    localparam int CNT_W       = $clog2(BOOTH_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        DIG_ZERO,
        DIG_POS1,
        DIG_NEG1,
        DIG_POS2,
        DIG_NEG2
    } booth_digit_e;

    // Window is {q[i+1], q[i], q[i-1]} of the multiplier.
    function automatic booth_digit_e booth_digit(input logic [2:0] window);
        booth_digit_e dig;
        dig = DIG_ZERO;
        case (window)
            3'b000, 3'b111: dig = DIG_ZERO;
            3'b001, 3'b010: dig = DIG_POS1;
            3'b011:         dig = DIG_POS2;
            3'b100:         dig = DIG_NEG2;
            3'b101, 3'b110: dig = DIG_NEG1;
            default:        dig = DIG_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Operand/result bundle between the multiplier and its requester.
// The requester drives start and operands; the multiplier returns status and product.
interface booth_mul_seq_if;
    import booth_mul_seq_pkg::*;

    logic              start;
    logic [WORD_W-1:0] multiplicand;
    logic [WORD_W-1:0] multiplier;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] product_hi;
    logic [WORD_W-1:0] product_lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_hi, product_lo
    );

endinterface

// File: rtl/booth_recode.sv
// Combinational radix-4 Booth recoder: 3-bit multiplier window to a signed
// 34-bit partial product of the multiplicand (0, +M, -M, +2M, -2M).
module booth_recode
    import booth_mul_seq_pkg::*;
(
    input  logic [2:0]             window_i,
    input  logic [WORD_W-1:0]      mcand_i,
    output logic signed [PP_W-1:0] pp_o
);

    logic signed [PP_W-1:0] m_ext;
    logic signed [PP_W-1:0] m2_ext;

    assign m_ext  = {{(PP_W-WORD_W){mcand_i[WORD_W-1]}}, mcand_i};
    assign m2_ext = m_ext <<< 1;

    always_comb begin
        // NOTE: default first so every path assigns pp_o and no latch is inferred.
        pp_o = '0;
        case (booth_digit(window_i))
            DIG_POS1: pp_o = m_ext;
            DIG_NEG1: pp_o = -m_ext;
            DIG_POS2: pp_o = m2_ext;
            DIG_NEG2: pp_o = -m2_ext;
            default:  pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed 32x32->64 multiplier, one radix-4 Booth digit per cycle.
// FSM, step counter, operand registers and accumulator live here.
module booth_mul_seq
    import booth_mul_seq_pkg::*;
(
    input  logic           Clock,
    input  logic           Clear,
    booth_mul_seq_if.slave bus
);

    state_e                 state_q;
    logic [CNT_W-1:0]       count_q;
    logic [WORD_W-1:0]      mcand_q;
    logic [WORD_W-1:0]      mplier_q;
    logic                   q_m1_q;
    logic signed [PP_W-1:0] acc_q;
    logic                   busy_q;
    logic                   done_q;
    logic [WORD_W-1:0]      prod_hi_q;
    logic [WORD_W-1:0]      prod_lo_q;

    logic signed [PP_W-1:0] pp;
    logic signed [PP_W-1:0] sum_d;
    logic signed [PP_W-1:0] acc_d;
    logic [WORD_W-1:0]      mplier_d;
    logic                   q_m1_d;
    logic                   last_step;

    booth_recode u_recode (
        .window_i ({mplier_q[1:0], q_m1_q}),
        .mcand_i  (mcand_q),
        .pp_o     (pp)
    );

    // {acc, mplier} shifts right by two as one 66-bit register; the multiplier
    // bits are consumed from the bottom as the sum bits enter from the top.
    assign sum_d     = acc_q + pp;
    assign acc_d     = sum_d >>> 2;
    assign mplier_d  = {sum_d[1:0], mplier_q[WORD_W-1:2]};
    assign q_m1_d    = mplier_q[1];
    assign last_step = (count_q == CNT_W'(BOOTH_STEPS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            q_m1_q    <= 1'b0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q  <= bus.multiplicand;
                        mplier_q <= bus.multiplier;
                        q_m1_q   <= 1'b0;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    q_m1_q   <= q_m1_d;
                    count_q  <= count_q + 1'b1;
                    if (last_step) begin
                        prod_hi_q <= acc_d[WORD_W-1:0];
                        prod_lo_q <= mplier_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.product_hi = prod_hi_q;
    assign bus.product_lo = prod_lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: a vector table of signed products plus
// hand-written sequences for ignored restarts and a mid-operation Clear.
module tb_booth_mul_seq;
    import booth_mul_seq_pkg::*;

    logic Clock = 1'b0;
    logic Clear;

    booth_mul_seq_if bus ();

    booth_mul_seq dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs[12];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issues one multiply and waits (bounded) for done; lat = 0 means no done seen.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic busy_seen);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_seen = bus.busy;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        busy_seen;
        int          dones;
        int          first;
        logic [63:0] seen;

        vecs[0]  = '{"small",      32'h0000_0012, 32'h0000_0014, 64'h0000_0000_0000_0168};
        vecs[1]  = '{"neg1_x_1",   32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{"min_x_min",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3]  = '{"max_x_min",  32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[4]  = '{"neg1_x_neg1",32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[5]  = '{"zero",       32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[6]  = '{"pow2_32",    32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[7]  = '{"neg2_x_3",   32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[8]  = '{"max_x_max",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[9]  = '{"min_x_1",    32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        vecs[10] = '{"3_x_min",    32'h0000_0003, 32'h8000_0000, 64'hFFFF_FFFE_8000_0000};
        vecs[11] = '{"shift16",    32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};

        Clear            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        #12;
        check("reset.prod", {bus.product_hi, bus.product_lo}, 64'h0);
        check("reset.busy_done", {bus.busy, bus.done}, 64'h0);
        tick();
        Clear = 1'b0;
        tick();

        foreach (vecs[k]) begin
            run_mul(vecs[k].a, vecs[k].b, lat, busy_seen);
            check({vecs[k].name, ".prod"}, {bus.product_hi, bus.product_lo}, vecs[k].prod);
            check({vecs[k].name, ".latency"}, lat, 16);
            check({vecs[k].name, ".busy"}, busy_seen, 1);
            tick();
            check({vecs[k].name, ".after_done"}, {bus.busy, bus.done}, 64'h0);
        end

        // Product must hold across idle cycles while the operand inputs change.
        bus.multiplicand = 32'hDEAD_BEEF;
        bus.multiplier   = 32'h0BAD_F00D;
        repeat (3) tick();
        check("hold.prod", {bus.product_hi, bus.product_lo}, 64'h0000_0001_2345_6780);

        // start during ITER is ignored and operand changes after the start edge do not matter.
        bus.multiplicand = 32'h12;
        bus.multiplier   = 32'h14;
        bus.start        = 1'b1;
        tick();
        dones = 0;
        first = 0;
        seen  = '0;
        for (int i = 1; i <= 30; i++) begin
            bus.start = (i == 5);
            if (i == 5) begin
                bus.multiplicand = 32'h3;
                bus.multiplier   = 32'h3;
            end
            if (i == 6) begin
                bus.multiplicand = 32'hCAFE_0001;
                bus.multiplier   = 32'h7777_0002;
            end
            tick();
            if (bus.done) begin
                dones++;
                if (first == 0) begin
                    first = i;
                    seen  = {bus.product_hi, bus.product_lo};
                end
            end
        end
        check("restart.done_count", dones, 1);
        check("restart.latency", first, 16);
        check("restart.prod", seen, 64'h168);

        // Clear in the middle of an operation aborts it with no later done.
        bus.start        = 1'b0;
        bus.multiplicand = 32'h12;
        bus.multiplier   = 32'h14;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        check("abort.busy_before", bus.busy, 1);
        Clear = 1'b1;
        #1;
        check("abort.immediate", {bus.busy, bus.done, bus.product_hi, bus.product_lo}, 64'h0);
        tick();
        Clear = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("abort.no_done", dones, 0);
        check("abort.busy", bus.busy, 0);
        check("abort.prod", {bus.product_hi, bus.product_lo}, 64'h0);

        run_mul(32'h2, 32'h3, lat, busy_seen);
        check("fresh.prod", {bus.product_hi, bus.product_lo}, 64'h6);
        check("fresh.latency", lat, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
